// File: rtl/mod12_seq_pkg.sv
// mod12_seq_pkg: opcodes, sequencer states and direction encodings for mod12_seq_ctrl
package mod12_seq_pkg;
  localparam logic [2:0] OP_NOP     = 3'd0;
  localparam logic [2:0] OP_RUN     = 3'd1;
  localparam logic [2:0] OP_STOP    = 3'd2;
  localparam logic [2:0] OP_STEP    = 3'd3;
  localparam logic [2:0] OP_LOAD    = 3'd4;
  localparam logic [2:0] OP_SET_DIR = 3'd5;
  localparam logic [2:0] OP_CLEAR   = 3'd6;
  localparam logic [2:0] OP_RSVD    = 3'd7;
  typedef enum logic [1:0] {STOPPED, RUNNING, STEPPING} state_e;
  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;
endpackage

// File: rtl/mod12_tick_prescaler.sv
// mod12_tick_prescaler: counts 0..TICK_DIV-1 while enabled and flags the terminal count
module mod12_tick_prescaler #(
  parameter int TICK_DIV = 4000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);
  localparam int W = $clog2(TICK_DIV);
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);
  logic [W-1:0] cnt_q, cnt_d;
  assign tick = enable && cnt_q == LAST;
  always_comb cnt_d = (clear || tick) ? '0 : enable ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/mod12_seq_ctrl.sv
// mod12_seq_ctrl: run/stop/step sequencer owning the mod-MOD count, its prescaler and direction.
// MOD12_SEQ_ONESHOT_EN: when defined, a wrapping advance while running also stops the sequencer.
module mod12_seq_ctrl import mod12_seq_pkg::*; #(
  parameter int TICK_DIV = 4000000,
  parameter int MOD      = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [3:0] cmd_data,
  output logic [3:0] count,
  output logic       carry,
  output logic       running,
  output logic       cmd_err,
  output logic       tick
);
`ifdef MOD12_SEQ_ONESHOT_EN
  localparam bit ONESHOT = 1'b1;
`else
  localparam bit ONESHOT = 1'b0;
`endif
  localparam logic [3:0] TOP = 4'(MOD - 1);
  state_e state_q, state_d;
  logic [3:0] count_q, count_d, nxt;
  logic dir_q, dir_d, carry_q, carry_d, err_q, err_d;
  logic acc, adv, wrap, pclr;
  mod12_tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
    .clk(clk), .reset(reset), .clear(pclr || state_d == STOPPED),
    .enable(state_q != STOPPED), .tick(tick)
  );
  assign cmd_ready = state_q != STEPPING;
  assign running   = state_q == RUNNING;
  assign count     = count_q;
  assign carry     = carry_q;
  assign cmd_err   = err_q;
  assign acc  = cmd_valid && cmd_ready;
  assign wrap = dir_q ? count_q == TOP : count_q == 4'd0;
  assign nxt  = wrap ? (dir_q ? 4'd0 : TOP) : (dir_q ? count_q + 4'd1 : count_q - 4'd1);
  // Any accepted command except NOP and SET_DIR takes this edge instead of the advance
  assign adv  = tick && !(acc && cmd_op != OP_NOP && cmd_op != OP_SET_DIR);
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    dir_d   = dir_q;
    carry_d = 1'b0;
    err_d   = 1'b0;
    pclr    = 1'b0;
    if (adv) begin
      count_d = nxt;
      carry_d = wrap;
      if (state_q == STEPPING || (ONESHOT && wrap)) state_d = STOPPED;
    end
    if (acc)
      case (cmd_op)
        OP_RUN:     if (state_q == STOPPED) begin state_d = RUNNING; pclr = 1'b1; end
        OP_STOP:    state_d = STOPPED;
        OP_STEP:    begin state_d = STEPPING; pclr = 1'b1; end
        OP_LOAD:    begin count_d = cmd_data <= TOP ? cmd_data : 4'd0; err_d = cmd_data > TOP; end
        OP_SET_DIR: dir_d = cmd_data[0];
        OP_CLEAR:   count_d = 4'd0;
        OP_RSVD:    err_d = 1'b1;
        default:    ;
      endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= STOPPED;
      count_q <= 4'd0;
      dir_q   <= DIR_UP;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      dir_q   <= dir_d;
      carry_q <= carry_d;
      err_q   <= err_d;
    end
endmodule

// File: tb/tb_mod12_seq_ctrl.sv
// tb_mod12_seq_ctrl: table-driven scoreboard bench for mod12_seq_ctrl with TICK_DIV=4, MOD=12
module tb_mod12_seq_ctrl;
  import mod12_seq_pkg::*;
`ifdef MOD12_SEQ_ONESHOT_EN
  localparam bit OS = 1'b1;
`else
  localparam bit OS = 1'b0;
`endif
  localparam logic [3:0] C0 = OS ? 4'd0 : 4'd1;
  typedef struct {
    logic v; logic [2:0] op; logic [3:0] d;
    logic tk; logic [3:0] cnt; logic cy, run, rdy, err;
  } vec_t;
  logic clk = 1'b0, reset = 1'b1, cmd_valid = 1'b0, cmd_ready, carry, running, cmd_err, tick;
  logic [2:0] cmd_op = 3'd0;
  logic [3:0] cmd_data = 4'd0, count;
  int checks = 0, errors = 0;
  vec_t tbl[$];
  vec_t sb[$];
  mod12_seq_ctrl #(.TICK_DIV(4), .MOD(12)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .count(count), .carry(carry),
    .running(running), .cmd_err(cmd_err), .tick(tick)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic add(input logic v, input logic [2:0] op, input logic [3:0] d, input logic tk,
                     input logic [3:0] cnt, input logic cy, input logic run, input logic rdy, input logic err);
    vec_t e;
    e.v = v; e.op = op; e.d = d; e.tk = tk; e.cnt = cnt; e.cy = cy; e.run = run; e.rdy = rdy; e.err = err;
    tbl.push_back(e);
  endtask
  task automatic idle(input int n, input logic tk, input logic [3:0] cnt, input logic run, input logic rdy);
    for (int i = 0; i < n; i++) add(1'b0, OP_NOP, 4'd0, tk, cnt, 1'b0, run, rdy, 1'b0);
  endtask
  initial begin
    vec_t e;
    int n;
    // Scenario 1: RUN, advances at edges 4 and 8
    add(1, OP_RUN, 0, 0, 0, 0, 1, 1, 0);
    idle(3, 0, 0, 1, 1);
    add(0, OP_NOP, 0, 1, 1, 0, 1, 1, 0);
    idle(3, 0, 1, 1, 1);
    add(0, OP_NOP, 0, 1, 2, 0, 1, 1, 0);
    add(1, OP_STOP, 0, 0, 2, 0, 0, 1, 0);
    // Scenario 4: illegal LOAD and reserved opcode
    add(1, OP_LOAD, 13, 0, 0, 0, 0, 1, 1);
    idle(1, 0, 0, 0, 1);
    add(1, OP_LOAD, 3, 0, 3, 0, 0, 1, 0);
    add(1, OP_RSVD, 0, 0, 3, 0, 0, 1, 1);
    idle(1, 0, 3, 0, 1);
    // Scenario 2: wrap 11 -> 0 with carry
    add(1, OP_LOAD, 11, 0, 11, 0, 0, 1, 0);
    add(1, OP_RUN, 0, 0, 11, 0, 1, 1, 0);
    idle(3, 0, 11, 1, 1);
    add(0, OP_NOP, 0, 1, 0, 1, !OS, 1, 0);
    idle(3, 0, 0, !OS, 1);
    add(0, OP_NOP, 0, !OS, C0, 0, !OS, 1, 0);
    add(1, OP_STOP, 0, 0, C0, 0, 0, 1, 0);
    // Scenario 5: LOAD on the tick edge suppresses the advance
    add(1, OP_RUN, 0, 0, C0, 0, 1, 1, 0);
    idle(3, 0, C0, 1, 1);
    add(0, OP_NOP, 0, 1, C0 + 4'd1, 0, 1, 1, 0);
    idle(3, 0, C0 + 4'd1, 1, 1);
    add(1, OP_LOAD, 5, 1, 5, 0, 1, 1, 0);
    idle(3, 0, 5, 1, 1);
    add(0, OP_NOP, 0, 1, 6, 0, 1, 1, 0);
    add(1, OP_STOP, 0, 0, 6, 0, 0, 1, 0);
    // Scenario 3: down-step from 0 wraps to 11; command during step is ignored
    add(1, OP_SET_DIR, 0, 0, 6, 0, 0, 1, 0);
    add(1, OP_LOAD, 0, 0, 0, 0, 0, 1, 0);
    add(1, OP_STEP, 0, 0, 0, 0, 0, 0, 0);
    add(1, OP_LOAD, 2, 0, 0, 0, 0, 0, 0);
    idle(2, 0, 0, 0, 0);
    add(0, OP_NOP, 0, 1, 11, 1, 0, 1, 0);
    idle(1, 0, 11, 0, 1);
    // Scenario 6 setup: step from 7 then reset mid-step
    add(1, OP_SET_DIR, 1, 0, 11, 0, 0, 1, 0);
    add(1, OP_LOAD, 7, 0, 7, 0, 0, 1, 0);
    add(1, OP_STEP, 0, 0, 7, 0, 0, 0, 0);
    idle(1, 0, 7, 0, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset_count", count, 0);
    chk("reset_carry", carry, 0);
    chk("reset_running", running, 0);
    chk("reset_ready", cmd_ready, 1);
    chk("reset_err", cmd_err, 0);
    chk("reset_tick", tick, 0);
    foreach (tbl[i]) begin
      cmd_valid = tbl[i].v; cmd_op = tbl[i].op; cmd_data = tbl[i].d;
      sb.push_back(tbl[i]);
      chk($sformatf("tick[%0d]", i), tick, tbl[i].tk);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk($sformatf("count[%0d]", i), count, e.cnt);
      chk($sformatf("carry[%0d]", i), carry, e.cy);
      chk($sformatf("running[%0d]", i), running, e.run);
      chk($sformatf("ready[%0d]", i), cmd_ready, e.rdy);
      chk($sformatf("err[%0d]", i), cmd_err, e.err);
    end
    cmd_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("async_count", count, 0);
    chk("async_ready", cmd_ready, 1);
    chk("async_running", running, 0);
    chk("async_carry", carry, 0);
    chk("async_err", cmd_err, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    chk("post_reset_carry", carry, 0);
    cmd_valid = 1'b1; cmd_op = OP_STEP; cmd_data = 4'd0;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    chk("step_ready", cmd_ready, 0);
    n = 0;
    while (count == 4'd0 && n < 12) begin
      @(posedge clk);
      #1 n++;
    end
    chk("step_latency", n, 4);
    chk("step_dir_up", count, 1);
    chk("step_carry", carry, 0);
    chk("step_done_ready", cmd_ready, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
